afifo_axis_packer: RTL

//  Downstream consumer of the LTC2324 sample async FIFO, in the FIFO read-clock domain.

---
 rtl/afifo_axis_packer_pkg.sv | 26 ++
 rtl/afifo_axis_packer_skid_buf.sv | 56 +++++
 rtl/afifo_axis_packer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/afifo_axis_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : afifo_axis_packer_pkg
//  Description : Shared state encoding, widths and helpers for the sample packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package afifo_axis_packer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;
    localparam int ITEM_W   = WORD_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Number of output words a given count of not-yet-buffered samples will occupy.
    function automatic logic [1:0] ceil_words(input logic [2:0] samples);
        logic [2:0] w_sum;
        w_sum = samples + 3'd1;
        return w_sum[2:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/afifo_axis_packer_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buf
//  Description : Two-entry AXIS register slice; reports occupancy for credit.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   occ_q;
    logic         w_pop;

    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign occ_o       = occ_q;
    assign w_pop       = out_valid_o & out_ready_i;

    // The writer never pushes into a full slice; upstream credit guarantees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (in_valid_i) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({in_valid_i, w_pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/afifo_axis_packer.sv
`default_nettype none
// ============================================================================
//  Module      : afifo_axis_packer
//  Description : Pops 16-bit FIFO samples, packs pairs into 32-bit AXIS words,
//                emits fixed-length packets that start/stop on boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module afifo_axis_packer
    import afifo_axis_packer_pkg::*;
#(
    parameter int PKT_WORDS = 256,
    parameter int CNT_W     = 32
) (
    input  logic                rd_clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    input  logic                fifo_empty,
    input  logic [9:0]          fifo_rd_data_count,
    output logic                fifo_rd_en,
    output logic [WORD_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                pkt_done,
    output logic [CNT_W-1:0]    pkt_count
);

    localparam int              RL_W    = $clog2(2 * PKT_WORDS + 1);
    localparam int              WI_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [RL_W-1:0] RL_LOAD = RL_W'(2 * PKT_WORDS);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(PKT_WORDS - 1);

    state_e                state_q, state_d;
    logic [RL_W-1:0]       reads_left_q, reads_left_d;
    logic                  inflight_q;
    logic                  half_q, half_d;
    logic [SAMPLE_W-1:0]   half_data_q, half_data_d;
    logic [WI_W-1:0]       asm_idx_q, asm_idx_d;
    logic [CNT_W-1:0]      pkt_count_q;
    logic                  pkt_done_q;

    logic [1:0]            w_occ;
    logic [1:0]            w_pend_words;
    logic                  w_credit;
    logic                  w_push;
    logic [ITEM_W-1:0]     w_push_item;
    logic [ITEM_W-1:0]     w_out_item;
    logic                  w_hs_last;
    logic                  w_unused_count;

    assign w_unused_count = ^fifo_rd_data_count;

    // Words still owed to the slice if we pop now: held half, in-flight sample, new sample.
    assign w_pend_words = ceil_words(3'(half_q) + 3'(inflight_q) + 3'd1);
    assign w_credit     = ({1'b0, w_occ} + {1'b0, w_pend_words}) <= 3'd2;
    assign fifo_rd_en   = (state_q == ST_STREAM) && !fifo_empty
                          && (reads_left_q != '0) && w_credit;

    assign w_hs_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d      = state_q;
        reads_left_d = reads_left_q;
        half_d       = half_q;
        half_data_d  = half_data_q;
        asm_idx_d    = asm_idx_q;
        w_push       = 1'b0;
        w_push_item  = {1'b0, fifo_dout, half_data_q};

        if (fifo_rd_en) begin
            reads_left_d = reads_left_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d      = ST_STREAM;
                    reads_left_d = RL_LOAD;
                end
            end
            ST_STREAM: begin
                if (w_hs_last) begin
                    if (en) begin
                        reads_left_d = RL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (inflight_q) begin
            if (!half_q) begin
                half_d      = 1'b1;
                half_data_d = fifo_dout;
            end else begin
                half_d      = 1'b0;
                w_push      = 1'b1;
                w_push_item = {(asm_idx_q == WI_LAST), fifo_dout, half_data_q};
                asm_idx_d   = (asm_idx_q == WI_LAST) ? '0 : asm_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            reads_left_q <= '0;
            inflight_q   <= 1'b0;
            half_q       <= 1'b0;
            half_data_q  <= '0;
            asm_idx_q    <= '0;
            pkt_count_q  <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            reads_left_q <= reads_left_d;
            inflight_q   <= fifo_rd_en;
            half_q       <= half_d;
            half_data_q  <= half_data_d;
            asm_idx_q    <= asm_idx_d;
            pkt_done_q   <= w_hs_last;
            if (w_hs_last) begin
                pkt_count_q <= pkt_count_q + 1'b1;
            end
        end
    end

    axis_skid_buf #(
        .W (ITEM_W)
    ) u_skid (
        .clk         (rd_clk),
        .rst         (rst),
        .in_data_i   (w_push_item),
        .in_valid_i  (w_push),
        .out_data_o  (w_out_item),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .occ_o       (w_occ)
    );

    assign m_axis_tdata = w_out_item[WORD_W-1:0];
    assign m_axis_tlast = w_out_item[WORD_W];
    assign busy         = (state_q == ST_STREAM);
    assign pkt_done     = pkt_done_q;
    assign pkt_count    = pkt_count_q;

endmodule
`default_nettype wire
